// File: rtl/pwm_duty_sched_pkg.sv
// Shared types and constants for the PWM duty scheduler.
// Holds the FSM state encoding, duty width and the ramp step helper.
package pwm_pkg;

    localparam int DUTY_W   = 4;
    localparam int DUTY_MAX = 15;
    localparam int GIDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_LOAD = 2'd2,
        ST_RAMP = 2'd3
    } state_t;

    // One ramp step toward tgt; lands exactly on tgt when within one step.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W-1:0] step);
        logic [DUTY_W-1:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            ramp_step = (diff <= step) ? tgt : cur + step;
        end else begin
            diff = cur - tgt;
            ramp_step = (diff <= step) ? tgt : cur - step;
        end
    endfunction

endpackage

// File: rtl/pwm_duty_sched_if.sv
// Requester / PWM-generator side bundle of the duty scheduler.
// slave = scheduler view, master = requester/generator view.
interface pwm_duty_sched_if #(parameter int NREQ = 3);
    import pwm_pkg::*;

    logic [NREQ-1:0]        req;
    logic [DUTY_W*NREQ-1:0] req_duty;
    logic                   ramp_en;
    logic                   period_end;
    logic [NREQ-1:0]        gnt;
    logic [DUTY_W-1:0]      duty;
    logic                   busy;
    logic                   done;

    modport slave (
        input  req, req_duty, ramp_en, period_end,
        output gnt, duty, busy, done
    );

    modport master (
        output req, req_duty, ramp_en, period_end,
        input  gnt, duty, busy, done
    );

endinterface

// File: rtl/pwm_duty_sched_rr_arb.sv
// Combinational round-robin picker: first set req bit at or after
// last_grant+1 (mod NREQ), returned one-hot.
module pwm_rr_arb
    import pwm_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]   req,
    input  logic [GIDX_W-1:0] last_grant,
    output logic [NREQ-1:0]   winner
);

    int              idx;
    logic            found;
    logic [NREQ-1:0] mask;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        mask   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(last_grant) + k) % NREQ;
            mask = NREQ'(1) << idx;
            if (!found && |(req & mask)) begin
                winner = mask;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_sched.sv
// Duty scheduler: arbitrates duty-change requests and applies the winning
// duty to the PWM generator only on period boundaries, jumping or ramping.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for any request
// ARB     | grant pulse visible, target latched, pick LOAD or RAMP
// LOAD    | next period_end jumps duty to target
// RAMP    | each period_end moves duty STEP toward target
module pwm_duty_sched
    import pwm_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int STEP = 1
) (
    input logic            clk,
    input logic            rst,
    pwm_duty_sched_if.slave bus
);

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [GIDX_W-1:0]   last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NREQ-1:0]     winner;
    logic [GIDX_W-1:0]   win_idx;
    logic [DUTY_W-1:0]   win_duty;
    logic [DUTY_W-1:0]   ramp_nxt;

    pwm_rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (bus.req),
        .last_grant (last_q),
        .winner     (winner)
    );

    always_comb begin
        win_idx  = '0;
        win_duty = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                win_idx  = GIDX_W'(i);
                win_duty = DUTY_W'(bus.req_duty >> (DUTY_W * i));
            end
        end
    end

    assign ramp_nxt = ramp_step(duty_q, target_q, DUTY_W'(STEP));

    // Arbitration is resolved on the IDLE->ARB edge so the grant flop is
    // already high during the ARB cycle.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        gnt_d    = '0;
        last_d   = last_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d  = ST_ARB;
                    gnt_d    = winner;
                    target_d = win_duty;
                    last_d   = win_idx;
                end
            end
            ST_ARB: begin
                state_d = (bus.ramp_en && (target_q != duty_q)) ? ST_RAMP : ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.period_end) begin
                    duty_d  = target_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (bus.period_end) begin
                    duty_d = ramp_nxt;
                    if (ramp_nxt == target_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            gnt_q    <= '0;
            last_q   <= GIDX_W'(NREQ - 1);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.duty = duty_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched: one STEP=1 and one STEP=4 instance, selected in
// turn, checked against a transaction-level model of grants and duty steps.
module tb_pwm_duty_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [2:0]  req_s;
    logic [11:0] req_duty_s;
    logic        ramp_en_s;
    logic        period_end_s;

    logic [2:0]  gnt_o;
    logic [3:0]  duty_o;
    logic        busy_o;
    logic        done_o;

    int n_chk = 0;
    int n_err = 0;

    int         m_duty;
    int         m_lg;
    int         step;
    logic [2:0] pending;
    int         pduty [3];

    always #5 clk = ~clk;

    pwm_duty_sched_if #(.NREQ(3)) bus_a ();
    pwm_duty_sched_if #(.NREQ(3)) bus_b ();

    assign bus_a.req        = sel ? 3'b000 : req_s;
    assign bus_a.req_duty   = req_duty_s;
    assign bus_a.ramp_en    = ramp_en_s;
    assign bus_a.period_end = sel ? 1'b0 : period_end_s;
    assign bus_b.req        = sel ? req_s : 3'b000;
    assign bus_b.req_duty   = req_duty_s;
    assign bus_b.ramp_en    = ramp_en_s;
    assign bus_b.period_end = sel ? period_end_s : 1'b0;

    assign gnt_o  = sel ? bus_b.gnt  : bus_a.gnt;
    assign duty_o = sel ? bus_b.duty : bus_a.duty;
    assign busy_o = sel ? bus_b.busy : bus_a.busy;
    assign done_o = sel ? bus_b.done : bus_a.done;

    pwm_duty_sched #(.NREQ(3), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pwm_duty_sched #(.NREQ(3), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] p, input int lg);
        for (int k = 1; k <= 3; k++) begin
            int j;
            j = (lg + k) % 3;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int d);
        pending[i] = 1'b1;
        pduty[i]   = d;
        req_duty_s[4*i +: 4] = d[3:0];
    endtask

    task automatic do_reset(input logic s);
        rst          = 1'b1;
        sel          = s;
        req_s        = '0;
        pending      = '0;
        period_end_s = 1'b0;
        ramp_en_s    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_duty", duty_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        rst    = 1'b0;
        m_duty = 0;
        m_lg   = 2;
        step   = s ? 4 : 1;
    endtask

    task automatic idle_pe(input int n);
        for (int k = 0; k < n; k++) begin
            period_end_s = 1'b1;
            @(negedge clk);
            period_end_s = 1'b0;
            chk("idle_pe_duty", duty_o, m_duty);
            chk("idle_pe_busy", busy_o, 0);
            chk("idle_pe_gnt", gnt_o, 0);
        end
    endtask

    // Called at a negedge with the DUT idle and req_s == pending != 0.
    task automatic run_txn(input bit hold, input bit pe_in_arb);
        int w, tgt, d, guard;
        bit ramp;
        int seq [$];
        w = rr_pick(pending, m_lg);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (gnt_o == 3'b000 && guard < 8);
        chk("gnt_latency", guard, 1);
        chk("gnt_onehot", gnt_o, 3'b001 << w);
        chk("busy_arb", busy_o, 1);
        if (gnt_o == 3'b000) return;

        tgt  = pduty[w];
        ramp = ramp_en_s;
        d    = m_duty;
        if (ramp && tgt != d) begin
            while (d != tgt) begin
                if (tgt > d) d = (tgt - d <= step) ? tgt : d + step;
                else         d = (d - tgt <= step) ? tgt : d - step;
                seq.push_back(d);
            end
        end else begin
            seq.push_back(tgt);
        end
        m_lg = w;
        if (!hold) pending[w] = 1'b0;
        req_s        = pending;
        period_end_s = pe_in_arb;
        @(negedge clk);
        period_end_s = 1'b0;
        ramp_en_s    = 1'($urandom_range(0, 1));
        chk("gnt_pulse", gnt_o, 0);
        chk("duty_after_arb", duty_o, m_duty);
        chk("busy_xfer", busy_o, 1);

        for (int k = 0; k < seq.size(); k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("duty_hold", duty_o, m_duty);
                chk("done_idle", done_o, 0);
                if (!hold && $urandom_range(0, 7) == 0) begin
                    int nb;
                    nb = $urandom_range(0, 2);
                    if (!pending[nb]) set_req(nb, $urandom_range(0, 15));
                    req_s = pending;
                end
            end
            period_end_s = 1'b1;
            @(negedge clk);
            period_end_s = 1'b0;
            m_duty = seq[k];
            chk("duty_step", duty_o, m_duty);
            chk("done_flag", done_o, (k == seq.size() - 1) ? 1 : 0);
            chk("busy_flag", busy_o, (k == seq.size() - 1) ? 0 : 1);
        end
    endtask

    task automatic random_phase(input int n);
        for (int it = 0; it < n; it++) begin
            if (pending == 3'b000) begin
                if ($urandom_range(0, 1) == 1) idle_pe($urandom_range(1, 3));
                for (int i = 0; i < 3; i++)
                    if ($urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, 15));
                if (pending == 3'b000) set_req($urandom_range(0, 2), $urandom_range(0, 15));
            end
            ramp_en_s = 1'($urandom_range(0, 1));
            req_s     = pending;
            run_txn(1'b0, 1'($urandom_range(0, 1)));
        end
        for (int it = 0; it < 4 && pending != 3'b000; it++) begin
            req_s = pending;
            run_txn(1'b0, 1'b0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sel          = 1'b0;
        req_s        = '0;
        req_duty_s   = '0;
        ramp_en_s    = 1'b0;
        period_end_s = 1'b0;
        pending      = '0;
        m_duty       = 0;
        m_lg         = 2;
        step         = 1;

        // STEP=1 instance
        do_reset(1'b0);
        idle_pe(3);

        set_req(0, 9);
        ramp_en_s = 1'b0;
        req_s     = pending;
        run_txn(1'b0, 1'b1);
        chk("jump_to_9", duty_o, 9);

        set_req(1, 2);
        req_s     = pending;
        ramp_en_s = 1'b0;
        run_txn(1'b0, 1'b0);
        set_req(2, 6);
        req_s     = pending;
        ramp_en_s = 1'b1;
        run_txn(1'b0, 1'b0);
        chk("ramp_to_6", duty_o, 6);

        set_req(1, 6);
        req_s     = pending;
        ramp_en_s = 1'b1;
        run_txn(1'b0, 1'b0);
        req_s = '0;

        do_reset(1'b0);
        set_req(0, 3);
        set_req(1, 8);
        set_req(2, 12);
        req_s     = pending;
        ramp_en_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                pending = '0;
                pending[0] = 1'b1;
            end
            run_txn(1'b1, 1'b0);
            chk("rr_order", m_lg, (i == 3) ? 0 : i);
        end
        pending = '0;
        req_s   = '0;

        do_reset(1'b0);
        set_req(0, 12);
        ramp_en_s = 1'b1;
        req_s     = pending;
        @(negedge clk);
        chk("abort_gnt", gnt_o, 3'b001);
        pending = '0;
        req_s   = '0;
        @(negedge clk);
        repeat (7) begin
            period_end_s = 1'b1;
            @(negedge clk);
            period_end_s = 1'b0;
        end
        chk("abort_mid_duty", duty_o, 7);
        chk("abort_mid_busy", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_duty", duty_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_gnt0", gnt_o, 0);
        @(negedge clk);
        rst    = 1'b0;
        m_duty = 0;
        m_lg   = 2;
        for (int i = 0; i < 3; i++) begin
            period_end_s = 1'b1;
            @(negedge clk);
            period_end_s = 1'b0;
            chk("abort_no_done", done_o, 0);
            chk("abort_idle", busy_o, 0);
        end

        random_phase(40);

        // STEP=4 instance
        do_reset(1'b1);
        set_req(0, 1);
        ramp_en_s = 1'b0;
        req_s     = pending;
        run_txn(1'b0, 1'b0);
        set_req(1, 15);
        ramp_en_s = 1'b1;
        req_s     = pending;
        run_txn(1'b0, 1'b1);
        chk("ramp4_up_15", duty_o, 15);
        set_req(2, 0);
        ramp_en_s = 1'b1;
        req_s     = pending;
        run_txn(1'b0, 1'b0);
        chk("ramp4_down_0", duty_o, 0);
        req_s = '0;

        random_phase(40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
